// File: rtl/adder_pkg.sv
// adder_pkg: width helpers and limits shared by the adder tree and its accumulator
package adder_pkg;
   localparam int ADDER_ACCUM_MAX_COUNT = 1024;
   function automatic int pos_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int sum_bits(input int bits, input int n);
      return bits + $clog2(n);
   endfunction
endpackage

// File: rtl/adder_accum_if.sv
// adder_accum_if: sample input, clear, and the frame-sum valid/ready output of adder_accum
interface adder_accum_if #(
   parameter int BITS  = 17,
   parameter int COUNT = 4
);
   import adder_pkg::*;
   localparam int OUT_BITS = sum_bits(BITS, COUNT);
   localparam int POS_BITS = pos_bits(COUNT);
   logic                valid;
   logic [BITS-1:0]     data_in;
   logic                clear;
   logic                ready;
   logic [OUT_BITS-1:0] o;
   logic                valid_out;
   logic                overflow;
   logic [POS_BITS-1:0] frame_pos;
   modport master (
      output valid, data_in, clear, ready,
      input  o, valid_out, overflow, frame_pos
   );
   modport slave (
      input  valid, data_in, clear, ready,
      output o, valid_out, overflow, frame_pos
   );
endinterface

// File: rtl/adder_accum_hold.sv
// adder_accum_hold: single-entry valid/ready output register; flags a load it cannot take
module adder_accum_hold #(
   parameter int W = 19
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         ready,
   output logic [W-1:0] o,
   output logic         valid_out,
   output logic         drop
);
   logic [W-1:0] r_o;
   logic         r_valid;
   logic         w_pop;
   assign w_pop     = r_valid & ready;
   assign drop      = load & r_valid & ~ready;
   assign o         = r_o;
   assign valid_out = r_valid;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_o     <= '0;
         r_valid <= 1'b0;
      end else if (load && (!r_valid || ready)) begin
         r_o     <= load_data;
         r_valid <= 1'b1;
      end else if (w_pop) begin
         r_valid <= 1'b0;
      end
   end
endmodule

// File: rtl/adder_accum.sv
// adder_accum: sums COUNT valid samples into one frame and presents it via a hold register
module adder_accum
   import adder_pkg::*;
#(
   parameter int BITS  = 17,
   parameter int COUNT = 4
) (
   input logic          clk,
   input logic          rst,
   adder_accum_if.slave bus
);
   localparam int OUT_BITS = sum_bits(BITS, COUNT);
   localparam int POS_BITS = pos_bits(COUNT);
   if (COUNT < 1 || COUNT > ADDER_ACCUM_MAX_COUNT) begin : g_bad_count
      $error("adder_accum: COUNT must be in 1..%0d", ADDER_ACCUM_MAX_COUNT);
   end
   logic [OUT_BITS-1:0] r_acc;
   logic [POS_BITS-1:0] r_pos;
   logic                r_ovf;
   logic                w_start;
   logic                w_done;
   logic                w_drop;
   logic [OUT_BITS-1:0] w_sum;
   // w_sum doubles as the frame result on the completing sample
   always_comb begin
      w_start = bus.clear || r_pos == '0;
      w_sum   = (w_start ? '0 : r_acc) + OUT_BITS'(bus.data_in);
      w_done  = bus.valid && (bus.clear ? COUNT == 1 : r_pos == POS_BITS'(COUNT - 1));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
         r_pos <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (bus.valid) begin
            r_acc <= w_sum;
            r_pos <= w_done ? '0 : bus.clear ? POS_BITS'(1) : r_pos + 1'b1;
         end else if (bus.clear) begin
            r_acc <= '0;
            r_pos <= '0;
         end
         r_ovf <= r_ovf | w_drop;
      end
   end
   adder_accum_hold #(.W(OUT_BITS)) u_hold (
      .clk       (clk),
      .rst       (rst),
      .load      (w_done),
      .load_data (w_sum),
      .ready     (bus.ready),
      .o         (bus.o),
      .valid_out (bus.valid_out),
      .drop      (w_drop)
   );
   assign bus.overflow  = r_ovf;
   assign bus.frame_pos = r_pos;
endmodule

// File: tb/tb_adder_accum.sv
// tb_adder_accum: COUNT=4 and COUNT=2 accumulators on shared stimulus, checked against a frame-sum model
module tb_adder_accum;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [16:0] din = '0;
   logic        clr = 1'b0;
   logic        rdy = 1'b0;
   int          tests = 0;
   int          fails = 0;
   bit          chk_en = 1'b0;
   int          n[2];
   longint      s[2];
   bit          pend[2];
   longint      mo[2];
   bit          movf[2];
   always #5 clk = ~clk;
   adder_accum_if #(.BITS(17), .COUNT(4)) b4 ();
   adder_accum_if #(.BITS(17), .COUNT(2)) b2 ();
   assign b4.valid = valid;
   assign b4.data_in = din;
   assign b4.clear = clr;
   assign b4.ready = rdy;
   assign b2.valid = valid;
   assign b2.data_in = din;
   assign b2.clear = clr;
   assign b2.ready = rdy;
   adder_accum #(.BITS(17), .COUNT(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
   adder_accum #(.BITS(17), .COUNT(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // frame model: running count and sum of the samples taken, one pending slot per sink
   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         int     cnt;
         bit     done;
         bit     pop;
         longint res;
         cnt  = (k == 0) ? 4 : 2;
         done = 1'b0;
         res  = 0;
         pop  = pend[k] && rdy;
         if (rst) begin
            n[k] = 0; s[k] = 0; pend[k] = 0; mo[k] = 0; movf[k] = 0;
         end else begin
            if (clr) begin
               n[k] = 0; s[k] = 0;
            end
            if (valid) begin
               s[k] += longint'(din);
               n[k]++;
               if (n[k] == cnt) begin
                  done = 1'b1; res = s[k]; n[k] = 0; s[k] = 0;
               end
            end
            if (done) begin
               if (!pend[k] || pop) begin
                  mo[k] = res; pend[k] = 1'b1;
               end else movf[k] = 1'b1;
            end else if (pop) pend[k] = 1'b0;
         end
      end
   endtask

   task automatic step(input bit v, input int d, input bit c, input bit r, input bit rs = 1'b0);
      valid = v;
      din   = 17'(d);
      clr   = c;
      rdy   = r;
      rst   = rs;
      model_update();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("c4_o", longint'(b4.o), mo[0]);
         chk("c4_valid_out", longint'(b4.valid_out), longint'(pend[0]));
         chk("c4_overflow", longint'(b4.overflow), longint'(movf[0]));
         chk("c4_frame_pos", longint'(b4.frame_pos), longint'(n[0]));
         chk("c2_o", longint'(b2.o), mo[1]);
         chk("c2_valid_out", longint'(b2.valid_out), longint'(pend[1]));
         chk("c2_overflow", longint'(b2.overflow), longint'(movf[1]));
         chk("c2_frame_pos", longint'(b2.frame_pos), longint'(n[1]));
      end
   end

   initial begin
      step(0, 0, 0, 0, 1);
      chk_en = 1'b1;
      chk("rst_o", longint'(b4.o), 0);
      chk("rst_valid_out", longint'(b4.valid_out), 0);
      chk("rst_frame_pos", longint'(b4.frame_pos), 0);
      // consecutive 1,2,3,4 with ready held high
      for (int i = 1; i <= 4; i++) begin
         step(1, i, 0, 1);
         chk("t1_frame_pos", longint'(b4.frame_pos), longint'(i % 4));
      end
      chk("t1_o", longint'(b4.o), 10);
      chk("t1_valid_out", longint'(b4.valid_out), 1);
      step(0, 0, 0, 1);
      chk("t1_valid_drop", longint'(b4.valid_out), 0);
      for (int i = 0; i < 4; i++) step(1, 'h1FFFF, 0, 1);
      chk("t2_no_trunc", longint'(b4.o), 'h7FFFC);
      step(0, 0, 0, 1);
      for (int i = 1; i <= 4; i++) step(1, i, 0, 0);
      chk("t3_a_o", longint'(b4.o), 10);
      chk("t3_a_ovf", longint'(b4.overflow), 0);
      for (int i = 5; i <= 8; i++) step(1, i, 0, 0);
      chk("t3_b_o", longint'(b4.o), 10);
      chk("t3_b_valid", longint'(b4.valid_out), 1);
      chk("t3_b_ovf", longint'(b4.overflow), 1);
      step(0, 0, 0, 1);
      chk("t3_pop_valid", longint'(b4.valid_out), 0);
      chk("t3_pop_ovf", longint'(b4.overflow), 1);
      step(0, 0, 0, 0, 1);
      step(1, 5, 0, 1);
      step(1, 6, 0, 1);
      chk("t4_o_11", longint'(b2.o), 11);
      step(1, 7, 0, 0);
      chk("t4_hold_11", longint'(b2.o), 11);
      step(1, 8, 0, 1);
      chk("t4_o_15", longint'(b2.o), 15);
      chk("t4_valid", longint'(b2.valid_out), 1);
      chk("t4_no_drop", longint'(b2.overflow), 0);
      step(0, 0, 0, 1, 1);
      step(1, 1, 0, 1);
      step(1, 2, 0, 1);
      step(1, 9, 1, 1);
      chk("t5_clear_pos", longint'(b4.frame_pos), 1);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 1);
      chk("t5_o", longint'(b4.o), 12);
      step(1, 1, 0, 1);
      step(0, 0, 1, 1);
      chk("t5_clear_alone", longint'(b4.frame_pos), 0);
      step(0, 0, 0, 1, 1);
      step(1, 3, 0, 1);
      step(1, 3, 0, 1);
      step(0, 0, 0, 1, 1);
      chk("t6_rst_o", longint'(b4.o), 0);
      chk("t6_rst_pos", longint'(b4.frame_pos), 0);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
      chk("t6_o", longint'(b4.o), 4);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
      chk("t6_ovf", longint'(b4.overflow), 1);
      step(0, 0, 0, 0, 1);
      chk("t6_rst_valid", longint'(b4.valid_out), 0);
      chk("t6_rst_ovf", longint'(b4.overflow), 0);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 9) < 7, int'($urandom_range(0, 'h1FFFF)), $urandom_range(0, 19) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/adder_accum.md
Name: adder_accum

Overview:
- Downstream consumer of the adder tree. Takes the tree's registered sum (o / valid_out) and accumulates COUNT consecutive valid results into one wider frame sum.
- Presents each frame sum through a valid/ready output register so a back-pressuring sink can hold it.
- The adder tree has no ready input. Any frame that completes while the output register is still occupied is dropped and flagged with a sticky flag.

Parameters:
- BITS, 17, width of each incoming sample (matches the adder tree's bits).
- COUNT, 4, number of valid samples per frame; legal range 1..1024.
- OUT_BITS, BITS+clog2(COUNT), width of the frame sum; derived, never overridden.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- valid  input  1  sample strobe (driven by the adder tree's valid_out)
- data_in  input  BITS  sample, unsigned (driven by the adder tree's o)
- clear  input  1  abort the current partial frame
- ready  input  1  sink accepts o this cycle
- o  output  OUT_BITS  frame sum
- valid_out  output  1  o holds an unconsumed frame sum
- overflow  output  1  sticky: at least one frame was dropped since reset
- frame_pos  output  clog2(COUNT) max 1  samples already taken in the current frame

Behaviour:
- Reset, when rst=1 at a clock edge: o=0, valid_out=0, overflow=0, frame_pos=0, internal accumulator=0. Reset also cancels any pending output. Reset mid-frame discards the partial frame.
- Width rule: data_in is zero-extended to OUT_BITS before addition. The sum cannot overflow by construction. No signed support.
- Accumulate, on valid=1 with clear=0:
  - If frame_pos==0, acc<=data_in.
  - Otherwise acc<=acc+data_in.
  - frame_pos increments.
- Frame completion is the valid=1 cycle where frame_pos==COUNT-1:
  - frame_pos<=0.
  - frame result = acc+data_in (data_in alone when COUNT=1).
- Latency: o/valid_out update at the clock edge that ends the COUNT-th valid cycle.
- Output register, per cycle. A "pop" is valid_out & ready.
  - Completion and (valid_out=0 or pop): o<=result, valid_out<=1. This covers back-to-back frames with no bubble.
  - Completion, valid_out=1, ready=0: result discarded, o unchanged, overflow<=1.
  - Pop without completion: valid_out<=0, o holds its last value.
  - Otherwise: o and valid_out are held. o must stay stable while valid_out=1 and ready=0.
- clear:
  - clear=1 with valid=0: frame_pos<=0, acc<=0.
  - clear=1 with valid=1: the sample becomes the first of a new frame. frame_pos<=1 (or a completion if COUNT=1), acc<=data_in.
  - clear never affects o, valid_out or overflow.
- valid=0 cycles: acc and frame_pos hold. No timeout; gaps between samples are unlimited.
- overflow clears only on rst.
- ready is ignored while valid_out=0.

Decomposition:
- Shared package adder_pkg:
  - clog2-based width helper used to derive OUT_BITS and the frame_pos width.
  - Constant ADDER_ACCUM_MAX_COUNT=1024.
- Sub-module adder_accum_hold: the single-entry valid/ready output register with drop detection.
  - Inputs: load, load_data, ready.
  - Outputs: o, valid_out, drop.
  - The top level holds the counter, the accumulator and the sticky flag.
- Parameter legality is checked at elaboration: error if COUNT<1 or COUNT>1024.

Test Plan:
1. BITS=17, COUNT=4, ready=1; samples 1,2,3,4 on consecutive cycles.
   - Required: o=10, valid_out=1 for exactly one cycle, one cycle after sample 4.
   - Required: frame_pos sequence 0,1,2,3,0.
2. COUNT=4; four samples of 0x1FFFF.
   - Required: o=0x7FFFC on 19 bits, no truncation.
3. COUNT=4, ready=0; send frames A (sum 10) and B (sum 26).
   - Required: o stays 10 with valid_out=1; frame B is dropped; overflow=1 after B's last sample.
   - Then assert ready for one cycle: valid_out=0 next cycle; overflow stays 1.
4. COUNT=2, ready=1; continuous samples 5,6,7,8.
   - Required: o=11, then o=15, valid_out high for two consecutive cycles.
   - Also: with ready=0 on A's valid_out cycle and ready=1 on the cycle B completes, the pop and load happen together, so o goes 11 then 15 with no drop.
5. COUNT=4; samples 1,2, then clear together with sample 9, then samples 1,1,1.
   - Required: o=12; the partial frame 1+2 is discarded.
   - Also: clear alone mid-frame results in frame_pos=0.
6. COUNT=4; samples 3,3, then rst=1 for one cycle, then samples 1,1,1,1.
   - Required: all outputs 0 during and after reset; next o=4.
   - Also: rst asserted while valid_out=1, ready=0 drops the pending frame and clears overflow.
